lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer directly upstream of the processor's data memory (single address pointer, 8-bit data, combinational read, clocked write).
- Accepts 8-bit or 16-bit load/store requests from the execute stage over a valid/ready handshake.
- Splits 16-bit accesses into two byte beats, little-endian, and returns one response per request.

Parameters:
- W, 8, data memory byte width; request data is 2*W.
- A, 8, data memory address width; memory depth is 2**A.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  block can accept a request this cycle
- ReqWrite  input  1  1 = store, 0 = load
- ReqWide  input  1  1 = 16-bit access, 0 = 8-bit access
- ReqAddr  input  A  byte address
- ReqWData  input  2*W  store data; only [W-1:0] is used for narrow stores
- RspValid  output  1  one-cycle response pulse
- RspRData  output  2*W  load data; 0 for stores
- RspErr  output  1  access rejected (optional feature only)
- MemAddr  output  A  drives memory DataAddress
- MemWData  output  W  drives memory DataIn
- MemWrEn  output  1  drives memory WriteEn
- MemRData  input  W  memory DataOut

Behaviour:
- Reset: clock is Clk; reset is Reset, synchronous, active-high. On Reset:
  - State = IDLE.
  - RspValid=0, RspRData=0, RspErr=0, MemWrEn=0, MemAddr=0, MemWData=0, internal capture registers cleared.
  - ReqReady = (state==IDLE) && !Reset, so it is 0 while Reset is high.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - ReqReady=1.
  - On ReqValid && ReqReady, register write/wide/addr/wdata and go to LO.
  - ReqValid without ready is held by the requester; no dropped requests.
- LO:
  - MemAddr = addr, MemWData = wdata[W-1:0], MemWrEn = write.
  - Load: capture MemRData into lo at the clock edge.
  - Next state: HI if wide, else RESP.
- HI:
  - MemAddr = addr+1 mod 2**A, so 0xFF wraps to 0x00.
  - MemWData = wdata[2W-1:W], MemWrEn = write.
  - Load: capture MemRData into hi. Next state: RESP.
- RESP:
  - RspValid=1 for exactly one cycle.
  - RspRData = {hi,lo} for wide loads, {0,lo} for narrow loads, 0 for stores.
  - Next state: IDLE. There is no response backpressure; the consumer must sample the pulse.
- Outside LO/HI:
  - MemWrEn=0 and MemAddr=0.
  - MemWrEn is combinational from state plus registered fields and never glitches high in IDLE or RESP.
- Latency (accept edge = cycle 0):
  - Narrow: RspValid in cycle 2.
  - Wide: RspValid in cycle 3.
  - Throughput is one request per 3 cycles (narrow) or 4 cycles (wide).
- Reset mid-operation:
  - Aborts immediately; no further memory write and no response.
  - A low byte already written by a wide store remains written.
- Load and store to the same address back-to-back: the store is fully complete before the next accept, so the following load sees the new data.

Optional Feature:
- Macro LSU_ALIGN_CHK_EN.
- Defined: a wide request with ReqAddr[0]==1 is accepted and goes directly IDLE->RESP with RspErr=1 and RspRData=0. There is no memory access (MemWrEn stays 0) and the response arrives in cycle 1.
- Undefined: misaligned wide accesses proceed normally, wrapping at 2**A as above, and RspErr is tied to 0.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum {IDLE, LO, HI, RESP}.
  - Default width constants W_DEF=8, A_DEF=8.
  - Request struct type (write, wide, addr, wdata).
- No sub-module warranted; the FSM, capture registers and address increment live in lsu_ctrl.

Test Plan:
- Reset the attached data memory (preload Core[0]=7, Core[1]=2, Core[2]=3, Core[15]=15); narrow load addr 0x0F -> RspValid in cycle 2, RspRData=0x000F.
- Wide load addr 0x00 -> MemAddr 0x00 then 0x01; RspValid in cycle 3, RspRData=0x0207.
- Wide store 0xBEEF to 0x20, then narrow loads of 0x20 and 0x21 -> 0x00EF and 0x00BE; the store response has RspRData=0.
- Wide store 0x1234 to 0xFF -> Core[0xFF]=0x34, Core[0x00]=0x12 (wrap). With LSU_ALIGN_CHK_EN: RspErr=1 in cycle 1, no write, Core[0xFF] unchanged.
- Assert Reset during HI of a wide store 0xAAAA to 0x40 -> Core[0x40]=0xAA, Core[0x41] unchanged, no RspValid, ReqReady=1 in the first cycle after Reset drops.
- ReqValid held continuously with alternating requests -> ReqReady low in LO/HI/RESP, every request answered exactly once, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and default widths for the load/store sequencer
package lsu_pkg;

  localparam int W_DEF = 8;
  localparam int A_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic                   write;
    logic                   wide;
    logic [A_DEF-1:0]       addr;
    logic [2*W_DEF-1:0]     wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - byte-beat load/store sequencer in front of the data memory
// LSU_ALIGN_CHK_EN: reject wide requests at odd addresses with RspErr and no memory access
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           ReqWrite,
  input  logic           ReqWide,
  input  logic [A-1:0]   ReqAddr,
  input  logic [2*W-1:0] ReqWData,
  output logic           RspValid,
  output logic [2*W-1:0] RspRData,
  output logic           RspErr,
  output logic [A-1:0]   MemAddr,
  output logic [W-1:0]   MemWData,
  output logic           MemWrEn,
  input  logic [W-1:0]   MemRData
);

  lsu_state_t     state_q, state_d;
  logic           write_q, write_d;
  logic           wide_q, wide_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [2*W-1:0] wdata_q, wdata_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;
  logic           err_q, err_d;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          wide_d  = ReqWide;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          lo_d    = '0;
          hi_d    = '0;
          err_d   = 1'b0;
          state_d = LO;
`ifdef LSU_ALIGN_CHK_EN
          if (ReqWide && ReqAddr[0]) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      LO: begin
        if (!write_q) lo_d = MemRData;
        state_d = wide_q ? HI : RESP;
      end
      HI: begin
        if (!write_q) hi_d = MemRData;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wide_q  <= wide_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign ReqReady = (state_q == IDLE) && !Reset;
  assign RspValid = (state_q == RESP);

  // Reset gates the write strobe so an abort stops the in-flight beat at this edge
  assign MemWrEn  = write_q && ((state_q == LO) || (state_q == HI)) && !Reset;
  assign MemAddr  = (state_q == LO) ? addr_q :
                    (state_q == HI) ? addr_q + A'(1) : '0;
  assign MemWData = (state_q == LO) ? wdata_q[W-1:0] :
                    (state_q == HI) ? wdata_q[2*W-1:W] : '0;

  always_comb begin
    RspRData = '0;
    if (state_q == RESP && !write_q && !err_q)
      RspRData = wide_q ? {hi_q, lo_q} : {{W{1'b0}}, lo_q};
  end

`ifdef LSU_ALIGN_CHK_EN
  assign RspErr = (state_q == RESP) && err_q;
`else
  assign RspErr = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed bench for lsu_ctrl with an attached byte memory model
module tb_lsu_ctrl;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqWide;
  logic [7:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        RspValid;
  logic [15:0] RspRData;
  logic        RspErr;
  logic [7:0]  MemAddr;
  logic [7:0]  MemWData;
  logic        MemWrEn;
  logic [7:0]  MemRData;

  logic [7:0]  core [256];
  logic        mem_init;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqWide(ReqWide),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspRData(RspRData), .RspErr(RspErr),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWrEn(MemWrEn), .MemRData(MemRData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  assign MemRData = core[MemAddr];

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) core[i] <= 8'h00;
      core[0]    <= 8'd7;
      core[1]    <= 8'd2;
      core[2]    <= 8'd3;
      core[15]   <= 8'd15;
      core[8'h41] <= 8'h55;
    end else if (MemWrEn) begin
      core[MemAddr] <= MemWData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge one cycle after the response.
  task automatic run_req(input logic wr, input logic wd, input logic [7:0] ad,
                         input logic [15:0] wdv, output logic [15:0] rd, output int lat,
                         output logic er, output logic [7:0] a0, output logic [7:0] a1,
                         output logic busy_ok, output logic pulse_ok);
    int w;
    ReqWrite = wr; ReqWide = wd; ReqAddr = ad; ReqWData = wdv; ReqValid = 1'b1;
    rd = '0; er = 1'b0; a0 = '0; a1 = '0; busy_ok = 1'b1; pulse_ok = 1'b0;
    w = 0;
    while (!ReqReady && w < 20) begin
      @(negedge Clk);
      w++;
    end
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    lat = 1;
    forever begin
      if (ReqReady) busy_ok = 1'b0;
      if (RspValid) begin
        rd = RspRData;
        er = RspErr;
        break;
      end
      if (lat == 1) a0 = MemAddr;
      if (lat == 2) a1 = MemAddr;
      if (lat >= 10) break;
      @(negedge Clk);
      lat++;
    end
    @(negedge Clk);
    pulse_ok = !RspValid;
  endtask

  typedef struct {
    logic        wr;
    logic        wd;
    logic [7:0]  ad;
    logic [15:0] wdv;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  logic [15:0] rd;
  int          lat;
  logic        er, busy_ok, pulse_ok;
  logic [7:0]  a0, a1;

  logic        hw [4];
  logic        hd [4];
  logic [7:0]  ha [4];
  logic [15:0] hwd[4];
  logic [15:0] hexp[4];
  int          hcyc[4];
  logic [15:0] got[4];
  int          gotc[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h0F, 16'h0000, 16'h000F, 2, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0207, 3, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 3, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'h00EF, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE, 2, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 3, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h05, 16'h1177, 16'h0000, 2, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'h0077, 2, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h06, 16'h0000, 16'h0000, 2, 1'b0};
`ifdef LSU_ALIGN_CHK_EN
    vecs[9] = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0000, 1, 1'b1};
`else
    vecs[9] = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0302, 3, 1'b0};
`endif

    hw[0] = 1'b1; hd[0] = 1'b0; ha[0] = 8'h30; hwd[0] = 16'h005A; hexp[0] = 16'h0000; hcyc[0] = 2;
    hw[1] = 1'b0; hd[1] = 1'b0; ha[1] = 8'h30; hwd[1] = 16'h0000; hexp[1] = 16'h005A; hcyc[1] = 5;
    hw[2] = 1'b1; hd[2] = 1'b1; ha[2] = 8'h32; hwd[2] = 16'hC3D4; hexp[2] = 16'h0000; hcyc[2] = 9;
    hw[3] = 1'b0; hd[3] = 1'b1; ha[3] = 8'h32; hwd[3] = 16'h0000; hexp[3] = 16'hC3D4; hcyc[3] = 13;

    Reset = 1'b1; mem_init = 1'b1;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAddr = '0; ReqWData = '0;
    repeat (3) @(negedge Clk);
    check("reset_ready", 32'(ReqReady), 0);
    check("reset_rspvalid", 32'(RspValid), 0);
    check("reset_rdata", 32'(RspRData), 0);
    check("reset_err", 32'(RspErr), 0);
    check("reset_wren", 32'(MemWrEn), 0);
    check("reset_addr", 32'(MemAddr), 0);
    check("reset_wdata", 32'(MemWData), 0);
    mem_init = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_ready", 32'(ReqReady), 1);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].wr, vecs[i].wd, vecs[i].ad, vecs[i].wdv, rd, lat, er, a0, a1, busy_ok, pulse_ok);
      check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_busy_ready_low", i), 32'(busy_ok), 1);
      check($sformatf("v%0d_single_pulse", i), 32'(pulse_ok), 1);
      if (!vecs[i].exp_err) check($sformatf("v%0d_addr_lo", i), 32'(a0), 32'(vecs[i].ad));
      if (vecs[i].wd && !vecs[i].exp_err)
        check($sformatf("v%0d_addr_hi", i), 32'(a1), 32'(vecs[i].ad + 8'd1));
    end
    check("core20", 32'(core[8'h20]), 32'hEF);
    check("core21", 32'(core[8'h21]), 32'hBE);

    run_req(1'b1, 1'b1, 8'hFF, 16'h1234, rd, lat, er, a0, a1, busy_ok, pulse_ok);
    check("wrap_rdata", 32'(rd), 0);
`ifdef LSU_ALIGN_CHK_EN
    check("wrap_err", 32'(er), 1);
    check("wrap_latency", 32'(lat), 1);
    check("wrap_coreFF", 32'(core[8'hFF]), 32'h00);
    check("wrap_core00", 32'(core[8'h00]), 32'h07);
`else
    check("wrap_err", 32'(er), 0);
    check("wrap_latency", 32'(lat), 3);
    check("wrap_addr_hi", 32'(a1), 32'h00);
    check("wrap_coreFF", 32'(core[8'hFF]), 32'h34);
    check("wrap_core00", 32'(core[8'h00]), 32'h12);
`endif

    ReqWrite = 1'b1; ReqWide = 1'b1; ReqAddr = 8'h40; ReqWData = 16'hAAAA; ReqValid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    check("abort_hi_addr", 32'(MemAddr), 32'h41);
    Reset = 1'b1;
    #1;
    check("abort_wren_gated", 32'(MemWrEn), 0);
    @(negedge Clk);
    check("abort_ready_in_reset", 32'(ReqReady), 0);
    check("abort_rspvalid_in_reset", 32'(RspValid), 0);
    Reset = 1'b0;
    #1;
    check("abort_ready_after", 32'(ReqReady), 1);
    begin
      int seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge Clk);
        if (RspValid) seen++;
      end
      check("abort_no_rsp", 32'(seen), 0);
    end
    check("abort_core40", 32'(core[8'h40]), 32'hAA);
    check("abort_core41", 32'(core[8'h41]), 32'h55);

    begin
      int idx = 0, nrsp = 0, readies = 0;
      logic acc;
      for (int c = 0; c < 30; c++) begin
        if (idx < 4) begin
          ReqWrite = hw[idx]; ReqWide = hd[idx]; ReqAddr = ha[idx]; ReqWData = hwd[idx];
          ReqValid = 1'b1;
        end else begin
          ReqValid = 1'b0;
        end
        if (RspValid) begin
          if (nrsp < 4) begin
            got[nrsp] = RspRData;
            gotc[nrsp] = c;
          end
          nrsp++;
        end
        if (ReqReady && idx < 4) readies++;
        acc = ReqReady && ReqValid;
        @(posedge Clk);
        if (acc) idx++;
        @(negedge Clk);
      end
      check("held_rsp_count", 32'(nrsp), 4);
      check("held_ready_count", 32'(readies), 4);
      for (int k = 0; k < 4; k++) begin
        if (k < nrsp) begin
          check($sformatf("held%0d_rdata", k), 32'(got[k]), 32'(hexp[k]));
          check($sformatf("held%0d_cycle", k), 32'(gotc[k]), 32'(hcyc[k]));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
